// File: rtl/insn_fetch_sequencer_if.sv
// insn_fetch_sequencer_if: control, memory and decode-side signals of the fetch sequencer.
interface insn_fetch_sequencer_if #(
  parameter int LEN_INSN      = 32,
  parameter int MEM_INSN_ADDR = 10,
  parameter int CNT_W         = 16
);
  logic                     start_i;
  logic [MEM_INSN_ADDR-1:0] start_addr_i;
  logic                     halt_i;
  logic                     stall_i;
  logic                     redirect_i;
  logic [MEM_INSN_ADDR-1:0] redirect_addr_i;
  logic [MEM_INSN_ADDR-1:0] mem_addr_o;
  logic [LEN_INSN-1:0]      mem_insn_i;
  logic                     valid_o;
  logic [LEN_INSN-1:0]      insn_o;
  logic [MEM_INSN_ADDR-1:0] addr_o;
  logic                     halted_o;
  logic [CNT_W-1:0]         retired_o;
  modport master (
    input  start_i, start_addr_i, halt_i, stall_i, redirect_i, redirect_addr_i, mem_insn_i,
    output mem_addr_o, valid_o, insn_o, addr_o, halted_o, retired_o
  );
  modport slave (
    output start_i, start_addr_i, halt_i, stall_i, redirect_i, redirect_addr_i, mem_insn_i,
    input  mem_addr_o, valid_o, insn_o, addr_o, halted_o, retired_o
  );
endinterface

// File: rtl/insn_fetch_sequencer.sv
// insn_fetch_sequencer: picks the instruction memory address each cycle and tags the returned word for decode.
module insn_fetch_sequencer #(
  parameter int LEN_INSN      = 32,
  parameter int MEM_INSN_ADDR = 10,
  parameter int CNT_W         = 16
) (
  input logic clk,
  input logic rst,
  insn_fetch_sequencer_if.master bus
);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t                   state_q, state_d;
  logic [MEM_INSN_ADDR-1:0] pc_q, pc_d, fl_addr_q, fl_addr_d, mem_addr;
  logic                     fl_valid_q, fl_valid_d, valid;
  logic [CNT_W-1:0]         retired_q, retired_d;
  assign valid = (state_q == RUN) && fl_valid_q;
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fl_addr_d  = fl_addr_q;
    fl_valid_d = fl_valid_q;
    retired_d  = retired_q;
    mem_addr   = pc_q;
    if (state_q != RUN) begin
      if (bus.start_i) begin
        state_d    = RUN;
        mem_addr   = bus.start_addr_i;
        fl_addr_d  = bus.start_addr_i;
        fl_valid_d = 1'b1;
        pc_d       = bus.start_addr_i + 1'b1;
        retired_d  = '0;
      end
    end else begin
      // a word counts as consumed whenever decode takes it, even in a halt or redirect cycle
      retired_d = retired_q + {{(CNT_W-1){1'b0}}, valid && !bus.stall_i};
      if (bus.halt_i) begin
        state_d    = HALT;
        fl_valid_d = 1'b0;
      end else if (bus.redirect_i) begin
        mem_addr   = bus.redirect_addr_i;
        fl_addr_d  = bus.redirect_addr_i;
        fl_valid_d = 1'b1;
        pc_d       = bus.redirect_addr_i + 1'b1;
      end else if (bus.stall_i) begin
        mem_addr = fl_addr_q;
      end else begin
        fl_addr_d  = pc_q;
        fl_valid_d = 1'b1;
        pc_d       = pc_q + 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      fl_addr_q  <= '0;
      fl_valid_q <= 1'b0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fl_addr_q  <= fl_addr_d;
      fl_valid_q <= fl_valid_d;
      retired_q  <= retired_d;
    end
  end
  assign bus.mem_addr_o = mem_addr;
  assign bus.valid_o    = valid;
  assign bus.insn_o     = bus.mem_insn_i;
  assign bus.addr_o     = fl_addr_q;
  assign bus.halted_o   = (state_q == HALT);
  assign bus.retired_o  = retired_q;
endmodule

// File: doc/insn_fetch_sequencer.md
Name: insn_fetch_sequencer

Overview:
- Program-counter sequencer and controller for the instruction fetch stage.
- Owns the synchronous-read instruction memory address port. The memory returns its Q one cycle after A is sampled on posedge clk.
- Decides which address is read each cycle: sequential, replay on stall, branch redirect, or start address.
- Tags the returned word with its address and a valid bit for decode; counts consumed instructions.
- Sits between the instruction memory and decode. Decode drives stall, redirect and halt.

Parameters:
- LEN_INSN, 32, instruction word width.
- MEM_INSN_ADDR, 10, instruction address width (word addressed).
- CNT_W, 16, width of the consumed-instruction counter.

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- start_i  input  1  begin fetching at start_addr_i; honoured only in IDLE or HALT.
- start_addr_i  input  MEM_INSN_ADDR  first fetch address.
- halt_i  input  1  stop fetching; honoured only in RUN.
- stall_i  input  1  decode cannot accept insn_o this cycle.
- redirect_i  input  1  branch taken; next fetch from redirect_addr_i.
- redirect_addr_i  input  MEM_INSN_ADDR  branch target.
- mem_addr_o  output  MEM_INSN_ADDR  address to memory A (combinational).
- mem_insn_i  input  LEN_INSN  memory Q.
- valid_o  output  1  insn_o/addr_o hold a live instruction.
- insn_o  output  LEN_INSN  equals mem_insn_i.
- addr_o  output  MEM_INSN_ADDR  address of insn_o.
- halted_o  output  1  state is HALT.
- retired_o  output  CNT_W  consumed-instruction count.

Behaviour:
- Registers:
  - state ∈ {IDLE, RUN, HALT}.
  - pc: next sequential address.
  - fl_addr: address read at the last edge.
  - fl_valid.
  - retired.
- Reset (rst low, async, any time including mid-operation):
  - state=IDLE; pc=0; fl_addr=0; fl_valid=0; retired=0.
  - Outputs: valid_o=0, halted_o=0, retired_o=0, mem_addr_o=0, addr_o=0.
- Combinational outputs:
  - valid_o = (state==RUN) & fl_valid.
  - addr_o = fl_addr.
  - insn_o = mem_insn_i.
- IDLE / HALT:
  - mem_addr_o = start_i ? start_addr_i : pc.
  - stall_i, redirect_i, halt_i ignored.
  - On start_i:
    - state←RUN; fl_addr←start_addr_i; fl_valid←1; pc←start_addr_i+1; retired←0.
    - valid_o rises the next cycle. Start-to-first-valid latency is 1 cycle.
- RUN, priority halt_i > redirect_i > stall_i > advance:
  - halt_i:
    - state←HALT; fl_valid←0; mem_addr_o=pc.
    - The current insn_o is still presented this cycle.
  - redirect_i:
    - mem_addr_o=redirect_addr_i; fl_addr←redirect_addr_i; fl_valid←1; pc←redirect_addr_i+1.
    - Zero bubble: the target is valid the next cycle.
    - Overrides a simultaneous stall_i.
  - stall_i (no redirect):
    - mem_addr_o=fl_addr (replays the same word); pc, fl_addr, fl_valid hold.
    - insn_o/addr_o stay stable while stalled.
  - advance:
    - mem_addr_o=pc; fl_addr←pc; fl_valid←1; pc←pc+1.
  - start_i ignored in RUN.
- Arithmetic: pc+1 is modulo 2^MEM_INSN_ADDR. Address 2^MEM_INSN_ADDR−1 is followed by 0 with no flag or stop.
- retired:
  - Increments by 1 on each edge with valid_o & ~stall_i, including in a halt_i or redirect_i cycle.
  - Wraps modulo 2^CNT_W.
  - Cleared on start_i.
- HALT: halted_o=1 and valid_o=0 until start_i.

Test Plan:
- Reset, then start_i=1 with start_addr_i=0x010 → mem_addr_o=0x010 that cycle. Next cycle valid_o=1, addr_o=0x010, mem_addr_o=0x011. Then addr_o 0x011, 0x012 on consecutive cycles.
- Stall of 3 cycles while addr_o=0x012 → mem_addr_o=0x012 and insn_o/addr_o stable for 3 cycles. After release addr_o=0x013. retired_o does not change during the stall.
- redirect_i with redirect_addr_i=0x200 while addr_o=0x005 → next cycle addr_o=0x200, valid_o=1, then 0x201. Repeat with stall_i=1 in the same cycle: identical result.
- start_addr_i=0x3FE (MEM_INSN_ADDR=10), run 4 cycles → addr_o sequence 0x3FE, 0x3FF, 0x000, 0x001.
- halt_i after 5 consumed insns → next cycle valid_o=0, halted_o=1, retired_o=6 (halt cycle counted). start_i=1 → retired_o=0, fetching resumes at start_addr_i.
- Assert rst low mid-RUN with stall_i=1 → immediately valid_o=0, state IDLE, retired_o=0. Inputs ignored until start_i after release.
